// File: rtl/elevator_pkg.sv
// Shared types and constants for the SCAN elevator scheduler and its timer.
package elevator_pkg;
   localparam int N_FLOORS_DEF = 10;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   typedef enum logic [1:0] {
      IDLE,
      MOVE_UP,
      MOVE_DOWN,
      DOOR_OPEN
   } state_t;
endpackage

// File: rtl/elevator_timer.sv
// Loadable down-counter shared by floor-to-floor travel and door dwell.
module elevator_timer #(
   parameter int CNT_W = 3
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   output logic             o_zero
);
   logic [CNT_W-1:0] r_cnt;

   // Holds at zero once expired so an idle scheduler sees a stable zero.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/elevator_scheduler.sv
// Collective-control (SCAN) elevator scheduler: latches calls, sweeps in one
// direction while work remains ahead, and dwells with the door open at each stop.
module elevator_scheduler
   import elevator_pkg::*;
#(
   parameter int N_FLOORS   = N_FLOORS_DEF,
   parameter int TRAVEL_CYC = 4,
   parameter int DOOR_CYC   = 3,
   parameter int CNT_W      = 3
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [N_FLOORS-1:0] i_hall_call,
   input  logic [N_FLOORS-1:0] i_car_call,
   input  logic                i_door_hold,
   output logic [N_FLOORS-1:0] o_floor,
   output logic [N_FLOORS-1:0] o_pending,
   output logic                o_move_up,
   output logic                o_move_down,
   output logic                o_door_open,
   output logic                o_dir_up,
   output logic                o_idle
);
   localparam logic [N_FLOORS-1:0] ONE        = {{(N_FLOORS-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]    TRAVEL_VAL = CNT_W'(TRAVEL_CYC - 1);
   localparam logic [CNT_W-1:0]    DOOR_VAL   = CNT_W'(DOOR_CYC - 1);

   state_t              r_state;
   logic [N_FLOORS-1:0] r_floor;
   logic [N_FLOORS-1:0] r_pending;
   logic                r_dir_up;
   logic                r_move_up;
   logic                r_move_down;
   logic                r_door_open;
   logic                r_idle;

   state_t              w_state_next;
   logic [N_FLOORS-1:0] w_floor_next;
   logic [N_FLOORS-1:0] w_floor_step;
   logic [N_FLOORS-1:0] w_clr;
   logic                w_dir_next;
   logic                w_tmr_load;
   logic [CNT_W-1:0]    w_tmr_val;
   logic                w_tmr_zero;
   logic                w_here;
   logic                w_above;
   logic                w_below;
   logic                w_new_here;

   // For a one-hot floor f, (f<<1)-1 covers f and everything beneath it.
   function automatic logic any_above(input logic [N_FLOORS-1:0] p,
                                      input logic [N_FLOORS-1:0] f);
      logic [N_FLOORS-1:0] le;
      le = (f << 1) - ONE;
      return |(p & ~le);
   endfunction

   function automatic logic any_below(input logic [N_FLOORS-1:0] p,
                                      input logic [N_FLOORS-1:0] f);
      return |(p & (f - ONE));
   endfunction

   elevator_timer #(.CNT_W(CNT_W)) u_timer (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (w_tmr_load),
      .i_load_val (w_tmr_val),
      .o_zero     (w_tmr_zero)
   );

   assign w_here       = |(r_pending & r_floor);
   assign w_above      = any_above(r_pending, r_floor);
   assign w_below      = any_below(r_pending, r_floor);
   assign w_new_here   = |((i_hall_call | i_car_call) & r_floor);
   assign w_floor_step = (r_state == MOVE_UP) ? (r_floor << 1) : (r_floor >> 1);

   always_comb begin
      w_state_next = r_state;
      w_floor_next = r_floor;
      w_dir_next   = r_dir_up;
      w_clr        = '0;
      w_tmr_load   = 1'b0;
      w_tmr_val    = DOOR_VAL;
      case (r_state)
         IDLE: begin
            if (w_here) begin
               w_state_next = DOOR_OPEN;
               w_clr        = r_floor;
               w_tmr_load   = 1'b1;
            end else if (w_above && (r_dir_up || !w_below)) begin
               w_state_next = MOVE_UP;
               w_dir_next   = DIR_UP;
               w_tmr_load   = 1'b1;
               w_tmr_val    = TRAVEL_VAL;
            end else if (w_below) begin
               w_state_next = MOVE_DOWN;
               w_dir_next   = DIR_DOWN;
               w_tmr_load   = 1'b1;
               w_tmr_val    = TRAVEL_VAL;
            end
         end
         MOVE_UP, MOVE_DOWN: begin
            // Arrival decisions look at the floor being entered, not the one left.
            if (w_tmr_zero) begin
               w_floor_next = w_floor_step;
               w_tmr_load   = 1'b1;
               if (|(r_pending & w_floor_step)) begin
                  w_state_next = DOOR_OPEN;
                  w_clr        = w_floor_step;
               end else if ((r_state == MOVE_UP)   && any_above(r_pending, w_floor_step) ||
                            (r_state == MOVE_DOWN) && any_below(r_pending, w_floor_step)) begin
                  w_tmr_val    = TRAVEL_VAL;
               end else begin
                  w_state_next = IDLE;
                  w_tmr_load   = 1'b0;
               end
            end
         end
         DOOR_OPEN: begin
            // Calls at the open floor are absorbed without ever reaching pending.
            w_clr = r_floor;
            if (i_door_hold || w_new_here) begin
               w_tmr_load = 1'b1;
            end else if (w_tmr_zero) begin
               if (r_dir_up ? w_above : w_below) begin
                  w_state_next = r_dir_up ? MOVE_UP : MOVE_DOWN;
                  w_tmr_load   = 1'b1;
                  w_tmr_val    = TRAVEL_VAL;
               end else if (r_dir_up ? w_below : w_above) begin
                  w_state_next = r_dir_up ? MOVE_DOWN : MOVE_UP;
                  w_dir_next   = ~r_dir_up;
                  w_tmr_load   = 1'b1;
                  w_tmr_val    = TRAVEL_VAL;
               end else begin
                  w_state_next = IDLE;
               end
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_floor     <= ONE;
         r_pending   <= '0;
         r_dir_up    <= DIR_UP;
         r_move_up   <= 1'b0;
         r_move_down <= 1'b0;
         r_door_open <= 1'b0;
         r_idle      <= 1'b1;
      end else begin
         r_state     <= w_state_next;
         r_floor     <= w_floor_next;
         r_pending   <= (r_pending | i_hall_call | i_car_call) & ~w_clr;
         r_dir_up    <= w_dir_next;
         r_move_up   <= (w_state_next == MOVE_UP);
         r_move_down <= (w_state_next == MOVE_DOWN);
         r_door_open <= (w_state_next == DOOR_OPEN);
         r_idle      <= (w_state_next == IDLE);
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         assert ($onehot(r_floor));
      end
   end

   assign o_floor     = r_floor;
   assign o_pending   = r_pending;
   assign o_move_up   = r_move_up;
   assign o_move_down = r_move_down;
   assign o_door_open = r_door_open;
   assign o_dir_up    = r_dir_up;
   assign o_idle      = r_idle;
endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: stimulus queues expected stops, a monitor checks
// each door-open episode (floor, direction, start cycle, length) as it completes.
module tb_elevator_scheduler;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] hall_call = '0;
   logic [9:0] car_call  = '0;
   logic       door_hold = 1'b0;
   logic [9:0] floor;
   logic [9:0] pending;
   logic       move_up, move_down, door_open, dir_up, idle;

   int cyc = 0;
   int checks = 0;
   int failures = 0;

   typedef struct {
      int fl;
      int dir;
      int start;
      int len;
   } stop_t;
   stop_t exp_q[$];

   elevator_scheduler #(
      .N_FLOORS(10), .TRAVEL_CYC(4), .DOOR_CYC(3), .CNT_W(3)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_hall_call (hall_call),
      .i_car_call  (car_call),
      .i_door_hold (door_hold),
      .o_floor     (floor),
      .o_pending   (pending),
      .o_move_up   (move_up),
      .o_move_down (move_down),
      .o_door_open (door_open),
      .o_dir_up    (dir_up),
      .o_idle      (idle)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   task automatic expect_stop(input int fl, input int dir, input int start, input int len);
      stop_t s;
      s.fl = fl; s.dir = dir; s.start = start; s.len = len;
      exp_q.push_back(s);
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_floor"}, 32'(floor), 32'h1);
      check({tag, "_pending"}, 32'(pending), 32'h0);
      check({tag, "_idle"}, 32'(idle), 32'h1);
      check({tag, "_dir"}, 32'(dir_up), 32'h1);
      check({tag, "_outs"}, {29'd0, move_up, move_down, door_open}, 32'h0);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset_state(tag);
   endtask

   // Monitor: one record per completed door-open episode.
   initial begin
      logic       prev_door;
      int         st_cyc, st_dir;
      logic [9:0] st_floor;
      stop_t      e;
      prev_door = 1'b0;
      st_cyc = 0; st_dir = 0; st_floor = '0;
      forever begin
         @(negedge clk);
         if (door_open && !prev_door) begin
            st_cyc   = cyc;
            st_floor = floor;
            st_dir   = int'(dir_up);
         end
         if (!door_open && prev_door) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_stop: got floor 0x%0h at cycle %0d, expected no stop", st_floor, st_cyc);
            end else begin
               e = exp_q.pop_front();
               check("stop_floor", 32'(st_floor), 32'(1) << e.fl);
               check("stop_dir",   32'(st_dir),   32'(e.dir));
               check("stop_start", 32'(st_cyc),   32'(e.start));
               check("stop_len",   32'(cyc - st_cyc), 32'(e.len));
            end
            $display("stop floor=0x%0h dir=%0d start=%0d len=%0d", st_floor, st_dir, st_cyc, cyc - st_cyc);
         end
         prev_door = door_open;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected bench completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, j, m;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_reset_state("reset0");

      // Call at the resting floor: door opens two cycles later, no travel.
      k = cyc;
      expect_stop(0, 1, k + 2, 3);
      hall_call = 10'h001; @(negedge clk); hall_call = '0;
      wait_cyc(k + 5);
      check("b_idle", 32'(idle), 32'h1);
      check("b_floor", 32'(floor), 32'h1);

      // Single trip 0 -> 5.
      k = cyc;
      expect_stop(5, 1, k + 22, 3);
      car_call = 10'h020; @(negedge clk); car_call = '0;
      check("c_move_k1", 32'(move_up), 32'h0);
      wait_cyc(k + 2);
      check("c_move_k2", 32'(move_up), 32'h1);
      wait_cyc(k + 21);
      check("c_move_k21", 32'(move_up), 32'h1);
      check("c_floor_k21", 32'(floor), 32'h010);
      wait_cyc(k + 22);
      check("c_move_k22", 32'(move_up), 32'h0);
      check("c_pending_k22", 32'(pending), 32'h0);
      check("c_floor_k22", 32'(floor), 32'h020);
      wait_cyc(k + 25);
      check("c_idle_k25", 32'(idle), 32'h1);

      // Two calls ahead: stop at 3 then continue to 7.
      do_reset("reset_d");
      k = cyc;
      expect_stop(3, 1, k + 14, 3);
      expect_stop(7, 1, k + 33, 3);
      car_call = 10'h088; @(negedge clk); car_call = '0;
      wait_cyc(k + 14);
      check("d_pending_at3", 32'(pending), 32'h080);
      wait_cyc(k + 25);
      check("d_dir_mid", 32'(dir_up), 32'h1);
      check("d_move_mid", 32'(move_up), 32'h1);
      wait_cyc(k + 36);
      check("d_idle", 32'(idle), 32'h1);
      check("d_floor", 32'(floor), 32'h080);

      // Go to 2, then 2 -> 8 with a call for 1 arriving mid-travel.
      do_reset("reset_e");
      k = cyc;
      expect_stop(2, 1, k + 10, 3);
      car_call = 10'h004; @(negedge clk); car_call = '0;
      wait_cyc(k + 13);
      check("e_idle_at2", 32'(idle), 32'h1);
      j = k + 14;
      wait_cyc(j);
      expect_stop(8, 1, j + 26, 3);
      expect_stop(1, 0, j + 57, 3);
      car_call = 10'h100; @(negedge clk); car_call = '0;
      wait_cyc(j + 5);
      hall_call = 10'h002; @(negedge clk); hall_call = '0;
      wait_cyc(j + 29);
      check("e_dir_rev", 32'(dir_up), 32'h0);
      check("e_move_down", 32'(move_down), 32'h1);
      wait_cyc(j + 56);
      check("e_pending_held", 32'(pending), 32'h002);
      check("e_floor_j56", 32'(floor), 32'h004);
      wait_cyc(j + 57);
      check("e_pending_clr", 32'(pending), 32'h0);
      wait_cyc(j + 60);
      check("e_idle", 32'(idle), 32'h1);

      // Door hold at floor 4 stretches the dwell to 5+3 cycles.
      k = cyc;
      expect_stop(4, 1, k + 14, 8);
      car_call = 10'h010; @(negedge clk); car_call = '0;
      wait_cyc(k + 14);
      door_hold = 1'b1;
      wait_cyc(k + 19);
      door_hold = 1'b0;
      wait_cyc(k + 21);
      check("f_door_last", 32'(door_open), 32'h1);
      wait_cyc(k + 22);
      check("f_idle", 32'(idle), 32'h1);

      // Call at the open floor during dwell: cleared at once, timer restarts.
      m = cyc;
      expect_stop(4, 1, m + 2, 5);
      hall_call = 10'h010; @(negedge clk); hall_call = '0;
      wait_cyc(m + 3);
      hall_call = 10'h010; @(negedge clk); hall_call = '0;
      check("f_pending_dwell", 32'(pending), 32'h0);
      check("f_door_dwell", 32'(door_open), 32'h1);
      wait_cyc(m + 7);
      check("f_idle2", 32'(idle), 32'h1);

      // Reset while travelling 3 -> 4 with calls for 4 and 9 outstanding.
      do_reset("reset_g0");
      k = cyc;
      car_call = 10'h210; @(negedge clk); car_call = '0;
      wait_cyc(k + 15);
      check("g_floor_pre", 32'(floor), 32'h008);
      check("g_pending_pre", 32'(pending), 32'h210);
      check("g_move_pre", 32'(move_up), 32'h1);
      do_reset("g_reset");
      wait_cyc(k + 30);
      check("g_still_idle", 32'(idle), 32'h1);
      check("g_still_floor", 32'(floor), 32'h1);

      check("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
